// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake body tracker.
//   COORD_W      : bits per row / column coordinate on the LED matrix
//   MAX_LEN      : ring buffer capacity in body segments
//   coord_t      : packed {row, col} coordinate as stored in the ring buffer
//   scan_state_t : collision-scan FSM states
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int COORD_W = 4;
    localparam int MAX_LEN = 64;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } coord_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/snake_ring_ram.sv
// -----------------------------------------------------------------------------
// snake_ring_ram
// DEPTH x WIDTH storage for the snake body history. One synchronous write port
// and two independent combinational read ports: one for the tail being
// dropped, one for the segment currently under collision scan.
// Ports:
//   clk        : system clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_tail_addr/o_tail_data : read port A (tail)
//   i_scan_addr/o_scan_data : read port B (collision scan)
// -----------------------------------------------------------------------------
module snake_ring_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_tail_addr,
    output logic [WIDTH-1:0] o_tail_data,
    input  logic [AW-1:0]    i_scan_addr,
    output logic [WIDTH-1:0] o_scan_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are never cleared: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_tail_data = r_mem[i_tail_addr];
    assign o_scan_data = r_mem[i_scan_addr];

endmodule

// File: rtl/snake_body_tracker.sv
// -----------------------------------------------------------------------------
// snake_body_tracker
// Keeps a circular history of snake head positions. On every accepted game
// tick the new head is pushed; when the stored body would exceed the
// effective length, the oldest segment is popped and reported so the display
// can clear that LED. After each move the older body segments are scanned
// one per clock against the new head to detect self-collision.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   slow_edge          : one-clk game tick pulse
//   move               : snake advances on this tick
//   head_row/head_col  : new head coordinate, valid with slow_edge
//   snake_length       : current length count (sampled in the accepting cycle)
//   tail_valid         : one-cycle pulse, tail_row/tail_col must be cleared
//   tail_row/tail_col  : coordinate of the dropped segment
//   busy               : collision scan in progress
//   self_hit           : sticky, new head matched a body segment
//   overrun            : sticky, tick arrived while busy
//   body_count         : number of segments currently stored
// -----------------------------------------------------------------------------
module snake_body_tracker
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = snake_pkg::MAX_LEN,
    parameter int COORD_W  = snake_pkg::COORD_W,
    localparam int CNT_W   = $clog2(MAX_LEN+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               slow_edge,
    input  logic               move,
    input  logic [COORD_W-1:0] head_row,
    input  logic [COORD_W-1:0] head_col,
    input  logic [7:0]         snake_length,
    output logic               tail_valid,
    output logic [COORD_W-1:0] tail_row,
    output logic [COORD_W-1:0] tail_col,
    output logic               busy,
    output logic               self_hit,
    output logic               overrun,
    output logic [CNT_W-1:0]   body_count
);

    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int SEG_W = 2*COORD_W;

    // Increment modulo MAX_LEN (works for non power-of-two depths too).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_LEN-1)) ? '0 : p + PTR_W'(1);
    endfunction

    scan_state_t        r_state;
    scan_state_t        w_state_next;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_scan_idx;
    logic [CNT_W-1:0]   r_body_count;
    logic [CNT_W-1:0]   r_scan_left;
    logic [SEG_W-1:0]   r_head;
    logic [SEG_W-1:0]   r_tail;
    logic               r_tail_valid;
    logic               r_self_hit;
    logic               r_overrun;

    logic               w_tick;
    logic               w_accept;
    logic [7:0]         w_eff_len;
    logic               w_pop;
    logic [CNT_W-1:0]   w_new_count;
    logic [CNT_W-1:0]   w_n;
    logic [PTR_W-1:0]   w_rd_post;
    logic [SEG_W-1:0]   w_head;
    logic [SEG_W-1:0]   w_tail_data;
    logic [SEG_W-1:0]   w_scan_data;
    logic               w_scan_match;

    assign w_tick   = slow_edge && move;
    assign w_accept = w_tick && (r_state == IDLE);
    assign w_head   = {head_row, head_col};

    // eff_len = max(1, min(snake_length, MAX_LEN)), using the value present in
    // the accepting cycle, so growth shows up one move later.
    always_comb begin
        if (snake_length > 8'(MAX_LEN)) begin
            w_eff_len = 8'(MAX_LEN);
        end else if (snake_length == 8'd0) begin
            w_eff_len = 8'd1;
        end else begin
            w_eff_len = snake_length;
        end
    end

    // Pop when the stored body plus the new head would exceed eff_len. Since
    // eff_len <= MAX_LEN this also keeps body_count from exceeding MAX_LEN.
    assign w_pop       = (9'(r_body_count) + 9'd1) > {1'b0, w_eff_len};
    assign w_new_count = w_pop ? r_body_count : r_body_count + CNT_W'(1);
    // Older segments to scan: everything stored except the new head.
    assign w_n         = w_new_count - CNT_W'(1);
    assign w_rd_post   = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;

    snake_ring_ram #(
        .DEPTH (MAX_LEN),
        .WIDTH (SEG_W)
    ) u_ram (
        .clk         (clk),
        .i_wr_en     (w_accept),
        .i_wr_addr   (r_wr_ptr),
        .i_wr_data   (w_head),
        .i_tail_addr (r_rd_ptr),
        .o_tail_data (w_tail_data),
        .i_scan_addr (r_scan_idx),
        .o_scan_data (w_scan_data)
    );

    assign w_scan_match = (r_state == SCAN) && (w_scan_data == r_head);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && (w_n != '0)) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                // Early exit on a hit, otherwise stop after the last segment.
                if (w_scan_match || (r_scan_left == CNT_W'(1))) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_scan_idx   <= '0;
            r_body_count <= '0;
            r_scan_left  <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_tail_valid <= 1'b0;
            r_self_hit   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_tail_valid <= 1'b0;

            if (w_accept) begin
                r_wr_ptr     <= ptr_inc(r_wr_ptr);
                r_head       <= w_head;
                r_body_count <= w_new_count;
                r_scan_idx   <= w_rd_post;
                r_scan_left  <= w_n;
                if (w_pop) begin
                    r_tail       <= w_tail_data;
                    r_tail_valid <= 1'b1;
                    r_rd_ptr     <= ptr_inc(r_rd_ptr);
                end
            end

            if (r_state == SCAN) begin
                r_scan_idx  <= ptr_inc(r_scan_idx);
                r_scan_left <= r_scan_left - CNT_W'(1);
                if (w_scan_match) begin
                    r_self_hit <= 1'b1;
                end
                // A tick during the scan is dropped entirely.
                if (w_tick) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign tail_valid = r_tail_valid;
    assign tail_row   = r_tail[SEG_W-1:COORD_W];
    assign tail_col   = r_tail[COORD_W-1:0];
    assign busy       = (r_state == SCAN);
    assign self_hit   = r_self_hit;
    assign overrun    = r_overrun;
    assign body_count = r_body_count;

endmodule

// File: tb/tb_snake_body_tracker.sv
// -----------------------------------------------------------------------------
// tb_snake_body_tracker
// Scoreboard bench for snake_body_tracker: a reference model of the body
// history predicts every dropped tail (queued at stimulus time and popped when
// tail_valid fires), scan durations, body_count and the sticky flags.
// -----------------------------------------------------------------------------
module tb_snake_body_tracker;
    import snake_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         slow_edge;
    logic         move;
    logic [3:0]   head_row;
    logic [3:0]   head_col;
    logic [7:0]   snake_length;
    logic         tail_valid;
    logic [3:0]   tail_row;
    logic [3:0]   tail_col;
    logic         busy;
    logic         self_hit;
    logic         overrun;
    logic [6:0]   body_count;

    int n_cmp = 0;
    int n_err = 0;

    coord_t model_body[$];
    coord_t exp_tail_q[$];
    bit     model_hit = 1'b0;
    bit     model_ovr = 1'b0;

    snake_body_tracker #(
        .MAX_LEN (64),
        .COORD_W (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .slow_edge    (slow_edge),
        .move         (move),
        .head_row     (head_row),
        .head_col     (head_col),
        .snake_length (snake_length),
        .tail_valid   (tail_valid),
        .tail_row     (tail_row),
        .tail_col     (tail_col),
        .busy         (busy),
        .self_hit     (self_hit),
        .overrun      (overrun),
        .body_count   (body_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every tail pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (tail_valid) begin
            chk("tail_pending", 32'(exp_tail_q.size() > 0), 32'd1);
            if (exp_tail_q.size() > 0) begin
                coord_t e;
                e = exp_tail_q.pop_front();
                chk("tail_coord", {24'd0, tail_row, tail_col}, {24'd0, e});
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        slow_edge = 1'b0;
        move = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_body.delete();
        model_hit = 1'b0;
        model_ovr = 1'b0;
    endtask

    // mode 0: normal tick; 1: second tick one cycle into the scan (overrun);
    // 2: reset asserted one cycle into the scan.
    task automatic do_tick(input logic [3:0] r, input logic [3:0] c,
                           input logic [7:0] len, input int mode);
        int     eff;
        bit     pop;
        int     n;
        int     exp_cyc;
        int     cyc;
        coord_t h;
        h   = '{row: r, col: c};
        eff = (int'(len) > 64) ? 64 : int'(len);
        if (eff < 1) eff = 1;
        pop = (model_body.size() + 1) > eff;

        @(negedge clk);
        slow_edge    = 1'b1;
        move         = 1'b1;
        head_row     = r;
        head_col     = c;
        snake_length = len;
        if (pop) exp_tail_q.push_back(model_body.pop_front());
        n       = model_body.size();
        exp_cyc = n;
        for (int i = 0; i < n; i++) begin
            if (model_body[i] == h) begin
                exp_cyc   = i + 1;
                model_hit = 1'b1;
                break;
            end
        end
        model_body.push_back(h);
        $display("tick head=(%0d,%0d) len=%0d pop=%0d scan=%0d mode=%0d", r, c, len, pop, exp_cyc, mode);

        @(negedge clk);
        chk("tail_valid", 32'(tail_valid), 32'(pop));
        chk("busy_start", 32'(busy), 32'(n > 0));

        if (mode == 2) begin
            slow_edge = 1'b0;
            move      = 1'b0;
            reset     = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            model_body.delete();
            model_hit = 1'b0;
            model_ovr = 1'b0;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_count", 32'(body_count), 32'd0);
            chk("rst_hit", 32'(self_hit), 32'd0);
            chk("rst_ovr", 32'(overrun), 32'd0);
            chk("rst_tail", 32'(tail_valid), 32'd0);
            return;
        end

        cyc = 0;
        if (mode == 1) begin
            head_row  = 4'hF;
            head_col  = 4'hF;
            model_ovr = 1'b1;
            @(negedge clk);
            cyc = 1;
        end
        slow_edge = 1'b0;
        move      = 1'b0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(cyc), 32'(exp_cyc));
        chk("body_count", 32'(body_count), 32'(model_body.size()));
        chk("self_hit", 32'(self_hit), 32'(model_hit));
        chk("overrun", 32'(overrun), 32'(model_ovr));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        reset        = 1'b1;
        slow_edge    = 1'b0;
        move         = 1'b0;
        head_row     = '0;
        head_col     = '0;
        snake_length = '0;
        repeat (3) @(negedge clk);
        chk("reset_tail_valid", 32'(tail_valid), 32'd0);
        chk("reset_tail", {24'd0, tail_row, tail_col}, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hit", 32'(self_hit), 32'd0);
        chk("reset_ovr", 32'(overrun), 32'd0);
        chk("reset_count", 32'(body_count), 32'd0);
        reset = 1'b0;

        // Length 3: first pop on the fourth tick.
        do_tick(4'd0, 4'd0, 8'd3, 0);
        do_tick(4'd0, 4'd1, 8'd3, 0);
        do_tick(4'd0, 4'd2, 8'd3, 0);
        do_tick(4'd0, 4'd3, 8'd3, 0);

        // Growth: pre-increment length sampled, so growth lands a move later.
        do_tick(4'd0, 4'd4, 8'd3, 0);
        do_tick(4'd0, 4'd5, 8'd4, 0);

        // Tick with move=0 does nothing.
        @(negedge clk);
        slow_edge = 1'b1;
        move      = 1'b0;
        head_row  = 4'd9;
        head_col  = 4'd9;
        @(negedge clk);
        slow_edge = 1'b0;
        chk("nomove_count", 32'(body_count), 32'd4);
        chk("nomove_busy", 32'(busy), 32'd0);
        chk("nomove_tail", 32'(tail_valid), 32'd0);

        // Full scan without hit, then a hit with early exit.
        do_tick(4'd1, 4'd5, 8'd4, 0);
        do_tick(4'd0, 4'd5, 8'd4, 0);

        // Second tick while the scan runs.
        do_tick(4'd2, 4'd0, 8'd4, 1);

        // Saturation at MAX_LEN and pointer wrap.
        apply_reset();
        for (int i = 0; i < 70; i++) begin
            v = 8'(i);
            do_tick(v[7:4], v[3:0], 8'd200, 0);
        end

        // Late hit plus overrun, then reset in the middle of a long scan.
        do_tick(4'd3, 4'd12, 8'd200, 1);
        do_tick(4'd6, 4'd4, 8'd200, 2);

        // Length 0 behaves as length 1.
        do_tick(4'd5, 4'd5, 8'd0, 0);
        do_tick(4'd5, 4'd6, 8'd0, 0);

        repeat (2) @(negedge clk);
        chk("tail_q_drained", 32'(exp_tail_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
